exec_mem_aux: RTL and testbench

- Execute/memory-stage helper unit for the 5-stage MIPS pipeline with CP0 exceptions.
- Combines three functions:
  - the E-stage ALU, with overflow exception detection;
  - the M-stage byte-enable and address-exception generator;
  - the W-stage branch-delay-slot tracker that feeds CP0 the BD bit and the EPC candidate.
- The ALU and byte-enable paths are combinational. Only the delay-slot tracker holds state.

---
 rtl/exec_mem_pkg.sv | 39 +++
 rtl/exec_mem_aux_bd_tracker.sv | 28 ++
 rtl/exec_mem_aux.sv | 143 ++++++++++++++
 tb/tb_exec_mem_aux.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_mem_pkg.sv
// Shared opcode, width, ExcCode and device-layout constants for exec_mem_aux.
package exec_mem_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_LUI   = 4'd11;
    localparam logic [3:0] OP_ADDU  = 4'd12;
    localparam logic [3:0] OP_SUBU  = 4'd13;
    localparam logic [3:0] OP_ADDLD = 4'd14;
    localparam logic [3:0] OP_ADDST = 4'd15;

    localparam logic [1:0] W_WORD = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_BYTE = 2'd2;
    localparam logic [1:0] W_RSVD = 2'd3;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] EXC_ADEL = 4'd4;
    localparam logic [3:0] EXC_ADES = 4'd5;
    localparam logic [3:0] EXC_OV   = 4'd12;

    localparam logic [31:0] DEV_CNT_OFS   = 32'd8;
    localparam logic [31:0] DEV_WIN_BYTES = 32'd12;

    // True when base <= addr < base + DEV_WIN_BYTES.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && (addr < (base + DEV_WIN_BYTES));
    endfunction

endpackage

// File: rtl/exec_mem_aux_bd_tracker.sv
// W-stage branch-delay-slot tracker: remembers whether the last real W instruction was a jump.
module bd_tracker (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_valid,
    input  logic        w_is_jump,
    input  logic [31:0] w_pc,
    output logic        bd_flag,
    output logic [31:0] bd_pc
);

    logic prev_jump_r;

    // Bubbles leave the history untouched so a delay slot after a stall is still seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_jump_r <= 1'b0;
        end else if (w_valid) begin
            prev_jump_r <= w_is_jump;
        end else begin
            prev_jump_r <= prev_jump_r;
        end
    end

    assign bd_flag = w_valid & prev_jump_r;
    assign bd_pc   = bd_flag ? (w_pc - 32'd4) : w_pc;

endmodule

// File: rtl/exec_mem_aux.sv
// E-stage ALU, M-stage byte-enable/address-fault logic and the W-stage delay-slot tracker.
// Build option: define OVF_TRAP_EN to report ALU overflow ExcCodes; otherwise alu_exc is 0.
module exec_mem_aux
    import exec_mem_pkg::*;
#(
    parameter logic [31:0] DM_TOP    = 32'h0000_2FFF,
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_result,
    output logic [3:0]  alu_exc,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_width,
    input  logic        mem_load,
    input  logic        mem_store,
    output logic [3:0]  mem_be,
    output logic [3:0]  mem_exc,
    input  logic        w_valid,
    input  logic [31:0] w_pc,
    input  logic        w_is_jump,
    output logic        bd_flag,
    output logic [31:0] bd_pc
);

    logic [31:0] sum_s;
    logic [31:0] diff_s;
    logic [4:0]  shamt_s;
    logic [31:0] alu_result_s;

    assign sum_s   = alu_src1 + alu_src2;
    assign diff_s  = alu_src1 - alu_src2;
    assign shamt_s = alu_src1[4:0];

    // ALU datapath; overflowing ops still return the wrapped value.
    always_comb begin
        alu_result_s = 32'd0;
        case (alu_op)
            OP_ADD, OP_ADDU, OP_ADDLD, OP_ADDST: alu_result_s = sum_s;
            OP_SUB, OP_SUBU:  alu_result_s = diff_s;
            OP_AND:           alu_result_s = alu_src1 & alu_src2;
            OP_OR:            alu_result_s = alu_src1 | alu_src2;
            OP_XOR:           alu_result_s = alu_src1 ^ alu_src2;
            OP_NOR:           alu_result_s = ~(alu_src1 | alu_src2);
            OP_SLL:           alu_result_s = alu_src2 << shamt_s;
            OP_SRL:           alu_result_s = alu_src2 >> shamt_s;
            OP_SRA:           alu_result_s = $signed(alu_src2) >>> shamt_s;
            OP_SLT:           alu_result_s = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
            OP_SLTU:          alu_result_s = {31'd0, (alu_src1 < alu_src2)};
            OP_LUI:           alu_result_s = {alu_src2[15:0], 16'h0000};
            default:          alu_result_s = 32'd0;
        endcase
    end

    assign alu_result = alu_result_s;

`ifdef OVF_TRAP_EN
    logic       add_ovf_s;
    logic       sub_ovf_s;
    logic [3:0] alu_exc_s;

    // Subtraction overflows when the operands' signs differ and the result flips sign from A.
    assign add_ovf_s = (alu_src1[31] == alu_src2[31]) && (sum_s[31]  != alu_src1[31]);
    assign sub_ovf_s = (alu_src1[31] != alu_src2[31]) && (diff_s[31] != alu_src1[31]);

    // Map overflow to the ExcCode implied by the opcode.
    always_comb begin
        alu_exc_s = EXC_NONE;
        case (alu_op)
            OP_ADD:   alu_exc_s = add_ovf_s ? EXC_OV   : EXC_NONE;
            OP_SUB:   alu_exc_s = sub_ovf_s ? EXC_OV   : EXC_NONE;
            OP_ADDLD: alu_exc_s = add_ovf_s ? EXC_ADEL : EXC_NONE;
            OP_ADDST: alu_exc_s = add_ovf_s ? EXC_ADES : EXC_NONE;
            default:  alu_exc_s = EXC_NONE;
        endcase
    end

    assign alu_exc = alu_exc_s;
`else
    assign alu_exc = EXC_NONE;
`endif

    logic        access_s;
    logic        in_dm_s;
    logic        in_dev0_s;
    logic        in_dev_s;
    logic [31:0] dev_ofs_s;
    logic        misaligned_s;
    logic        fault_s;
    logic [3:0]  be_raw_s;

    assign access_s     = mem_load | mem_store;
    assign in_dm_s      = (mem_addr <= DM_TOP);
    assign in_dev0_s    = in_window(mem_addr, DEV0_BASE);
    assign in_dev_s     = in_dev0_s | in_window(mem_addr, DEV1_BASE);
    assign dev_ofs_s    = in_dev0_s ? (mem_addr - DEV0_BASE) : (mem_addr - DEV1_BASE);
    assign misaligned_s = ((mem_width == W_WORD) && (mem_addr[1:0] != 2'b00)) ||
                          ((mem_width == W_HALF) && mem_addr[0]);

    // Raw lane select plus prioritised fault detection.
    always_comb begin
        be_raw_s = 4'b0000;
        fault_s  = 1'b0;
        case (mem_width)
            W_WORD:  be_raw_s = 4'b1111;
            W_HALF:  be_raw_s = mem_addr[1] ? 4'b1100 : 4'b0011;
            W_BYTE:  be_raw_s = 4'b0001 << mem_addr[1:0];
            default: be_raw_s = 4'b0000;
        endcase
        if (mem_width == W_RSVD) begin
            fault_s = 1'b1;
        end else if (misaligned_s) begin
            fault_s = 1'b1;
        end else if (!in_dm_s && !in_dev_s) begin
            fault_s = 1'b1;
        end else if (in_dev_s && (mem_width != W_WORD)) begin
            fault_s = 1'b1;
        end else if (in_dev_s && mem_store && (dev_ofs_s == DEV_CNT_OFS)) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
    end

    // A load+store combination is treated as a store.
    assign mem_be  = (access_s && !fault_s) ? be_raw_s : 4'b0000;
    assign mem_exc = (access_s && fault_s) ? (mem_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;

    bd_tracker u_bd_tracker (
        .clk       (clk),
        .reset     (reset),
        .w_valid   (w_valid),
        .w_is_jump (w_is_jump),
        .w_pc      (w_pc),
        .bd_flag   (bd_flag),
        .bd_pc     (bd_pc)
    );

endmodule

// File: tb/tb_exec_mem_aux.sv
// Randomised self-checking bench for exec_mem_aux against an arithmetic reference model.
module tb_exec_mem_aux;

    logic        clk;
    logic        reset;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  alu_exc;
    logic [31:0] mem_addr;
    logic [1:0]  mem_width;
    logic        mem_load;
    logic        mem_store;
    logic [3:0]  mem_be;
    logic [3:0]  mem_exc;
    logic        w_valid;
    logic [31:0] w_pc;
    logic        w_is_jump;
    logic        bd_flag;
    logic [31:0] bd_pc;

    int n_checks = 0;
    int n_fail   = 0;
    logic model_last_jump;

    exec_mem_aux dut (
        .clk        (clk),
        .reset      (reset),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_exc    (alu_exc),
        .mem_addr   (mem_addr),
        .mem_width  (mem_width),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_be     (mem_be),
        .mem_exc    (mem_exc),
        .w_valid    (w_valid),
        .w_pc       (w_pc),
        .w_is_jump  (w_is_jump),
        .bd_flag    (bd_flag),
        .bd_pc      (bd_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] e);
        longint sa, sb, wide;
        logic   ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        wide = 64'sd0;
        r = 32'd0;
        e = 4'd0;
        case (op)
            4'd0, 4'd12, 4'd14, 4'd15: begin wide = sa + sb; r = wide[31:0]; end
            4'd1, 4'd13: begin wide = sa - sb; r = wide[31:0]; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = b << a[4:0];
            4'd7:  r = b >> a[4:0];
            4'd8:  begin wide = sb >>> a[4:0]; r = wide[31:0]; end
            4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11: r = b * 32'd65536;
            default: r = 32'd0;
        endcase
        ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`ifdef OVF_TRAP_EN
        if (ovf && (op == 4'd0 || op == 4'd1)) e = 4'd12;
        if (ovf && op == 4'd14) e = 4'd4;
        if (ovf && op == 4'd15) e = 4'd5;
`else
        if (ovf) e = 4'd0;
`endif
    endfunction

    function automatic void mem_model(input logic [31:0] addr, input logic [1:0] w,
                                      input logic ld, input logic st,
                                      output logic [3:0] be, output logic [3:0] e);
        int          size;
        int          tmp;
        logic        fault;
        logic        is_dev;
        logic [31:0] ofs;
        be = 4'd0;
        e  = 4'd0;
        if (ld || st) begin
            size   = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
            is_dev = 1'b0;
            ofs    = 32'd0;
            if (addr >= 32'h7F00 && addr < 32'h7F0C) begin is_dev = 1'b1; ofs = addr - 32'h7F00; end
            if (addr >= 32'h7F10 && addr < 32'h7F1C) begin is_dev = 1'b1; ofs = addr - 32'h7F10; end
            fault = 1'b0;
            if (w == 2'd3) fault = 1'b1;
            else if ((addr % size) != 0) fault = 1'b1;
            else if (addr > 32'h2FFF && !is_dev) fault = 1'b1;
            else if (is_dev && size != 4) fault = 1'b1;
            else if (is_dev && st && ofs == 32'd8) fault = 1'b1;
            tmp = ((1 << size) - 1) << (addr % 4);
            be  = fault ? 4'd0 : tmp[3:0];
            e   = fault ? (st ? 4'd5 : 4'd4) : 4'd0;
        end
    endfunction

    // Check every output against the model, then let a clock edge update the tracker.
    task automatic tick(input string tag);
        logic [31:0] r;
        logic [3:0]  e, be, me;
        logic        fl;
        #1;
        alu_model(alu_op, alu_src1, alu_src2, r, e);
        mem_model(mem_addr, mem_width, mem_load, mem_store, be, me);
        fl = w_valid && model_last_jump;
        check_val({tag, ".alu_result"}, alu_result, r);
        check_val({tag, ".alu_exc"}, {28'd0, alu_exc}, {28'd0, e});
        check_val({tag, ".mem_be"}, {28'd0, mem_be}, {28'd0, be});
        check_val({tag, ".mem_exc"}, {28'd0, mem_exc}, {28'd0, me});
        check_val({tag, ".bd_flag"}, {31'd0, bd_flag}, {31'd0, fl});
        check_val({tag, ".bd_pc"}, bd_pc, fl ? (w_pc - 32'd4) : w_pc);
        @(posedge clk);
        if (reset && w_valid) model_last_jump = w_is_jump;
        @(negedge clk);
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op = op; alu_src1 = a; alu_src2 = b;
    endtask

    task automatic set_mem(input logic [31:0] addr, input logic [1:0] w, input logic ld, input logic st);
        mem_addr = addr; mem_width = w; mem_load = ld; mem_store = st;
    endtask

    task automatic set_w(input logic v, input logic [31:0] pc, input logic j);
        w_valid = v; w_pc = pc; w_is_jump = j;
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 32'h3003));
            1: return 32'h7EF8 + 32'($urandom_range(0, 48));
            2: return 32'h2FF8 + 32'($urandom_range(0, 16));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        model_last_jump = 1'b0;
        reset = 1'b0;
        set_alu(4'd0, 32'd0, 32'd0);
        set_mem(32'd0, 2'd0, 1'b0, 1'b0);
        set_w(1'b1, 32'h0000_1234, 1'b0);
        #2;
        check_val("reset.bd_flag", {31'd0, bd_flag}, 32'd0);
        check_val("reset.bd_pc", bd_pc, 32'h0000_1234);
        @(negedge clk);
        reset = 1'b1;

        // Directed ALU cases
        set_alu(4'd0, 32'h7FFF_FFFF, 32'd1);
        #1;
        check_val("add_ovf.result", alu_result, 32'h8000_0000);
`ifdef OVF_TRAP_EN
        check_val("add_ovf.exc", {28'd0, alu_exc}, 32'd12);
`else
        check_val("add_ovf.exc", {28'd0, alu_exc}, 32'd0);
`endif
        set_alu(4'd12, 32'h7FFF_FFFF, 32'd1);
        #1;
        check_val("addu.exc", {28'd0, alu_exc}, 32'd0);
        set_alu(4'd8, 32'd4, 32'h8000_0000);
        #1;
        check_val("sra.result", alu_result, 32'hF800_0000);
        set_alu(4'd9, 32'hFFFF_FFFF, 32'd1);
        #1;
        check_val("slt.result", alu_result, 32'd1);
        set_alu(4'd10, 32'hFFFF_FFFF, 32'd1);
        #1;
        check_val("sltu.result", alu_result, 32'd0);

        // Directed memory cases
        set_mem(32'h1002, 2'd1, 1'b0, 1'b1);
        #1;
        check_val("sh_1002.be", {28'd0, mem_be}, 32'hC);
        check_val("sh_1002.exc", {28'd0, mem_exc}, 32'd0);
        set_mem(32'h1001, 2'd1, 1'b1, 1'b0);
        #1;
        check_val("lh_1001.be", {28'd0, mem_be}, 32'd0);
        check_val("lh_1001.exc", {28'd0, mem_exc}, 32'd4);
        set_mem(32'h7F04, 2'd0, 1'b1, 1'b0);
        #1;
        check_val("lw_7f04.be", {28'd0, mem_be}, 32'hF);
        check_val("lw_7f04.exc", {28'd0, mem_exc}, 32'd0);
        set_mem(32'h7F08, 2'd0, 1'b0, 1'b1);
        #1;
        check_val("sw_7f08.exc", {28'd0, mem_exc}, 32'd5);
        set_mem(32'h7F00, 2'd2, 1'b1, 1'b0);
        #1;
        check_val("lb_7f00.exc", {28'd0, mem_exc}, 32'd4);
        set_mem(32'h3000, 2'd0, 1'b1, 1'b0);
        #1;
        check_val("lw_3000.exc", {28'd0, mem_exc}, 32'd4);
        @(negedge clk);

        // Delay-slot tracking across a bubble
        set_w(1'b1, 32'h3000, 1'b1);
        tick("w_jump");
        set_w(1'b0, 32'h0000_0000, 1'b0);
        tick("w_bubble");
        set_w(1'b1, 32'h3004, 1'b0);
        #1;
        check_val("w_slot.bd_flag", {31'd0, bd_flag}, 32'd1);
        check_val("w_slot.bd_pc", bd_pc, 32'h3000);
        tick("w_slot");
        set_w(1'b1, 32'h3008, 1'b0);
        #1;
        check_val("w_next.bd_flag", {31'd0, bd_flag}, 32'd0);
        tick("w_next");

        // Reset mid-stream clears the tracker at once
        set_w(1'b1, 32'h300C, 1'b1);
        tick("w_jump2");
        set_w(1'b1, 32'h3010, 1'b0);
        #1;
        check_val("pre_rst.bd_flag", {31'd0, bd_flag}, 32'd1);
        reset = 1'b0;
        #1;
        check_val("mid_rst.bd_flag", {31'd0, bd_flag}, 32'd0);
        model_last_jump = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("post_rst.bd_pc", bd_pc, 32'h3010);
        tick("post_rst");

        // Randomised sweep of all three paths together
        for (int i = 0; i < 400; i++) begin
            set_alu(4'($urandom_range(0, 15)), pick_word(), pick_word());
            set_mem(pick_addr(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_w(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
